// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI bus arbiter.
// The SPI_ARB_LED_STRETCH_EN build option is handled in spi_bus_arbiter.sv.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  localparam logic DEV_FLASH = 1'b0;
  localparam logic DEV_SD    = 1'b1;

  localparam int BIT_CNT_W = 4;

  // Chip-select pair {sd_cs_n, flash_cs_n} for a granted device
  function automatic logic [1:0] cs_for_dev(input logic dev);
    logic [1:0] cs;
    if (dev == DEV_SD) cs = 2'b01;
    else               cs = 2'b10;
    return cs;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter: SCLK divider, MSB-first 8-bit exchange, busy/done.
// A start arriving while busy or during the done cycle is dropped.
module spi_byte_shifter
  import spi_arb_pkg::*;
#(
  parameter int DIV = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] txd,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rxd,
  output logic       sclk,
  output logic       mosi
);

  localparam int DIV_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [BIT_CNT_W-1:0] HALF_LAST = {BIT_CNT_W{1'b1}};

  logic [DIV_W-1:0]     div_cnt_r;
  logic [BIT_CNT_W-1:0] half_cnt_r;
  logic [7:0]           tx_sh_r;
  logic [7:0]           rx_sh_r;
  logic                 accept_s;
  logic                 tick_s;

  assign accept_s = start & ~busy & ~done;
  assign tick_s   = (div_cnt_r == DIV_W'(DIV));

  // Byte engine: even half-periods raise SCLK and sample, odd ones lower it and shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      rxd        <= 8'h00;
      sclk       <= 1'b0;
      mosi       <= 1'b1;
      div_cnt_r  <= {DIV_W{1'b0}};
      half_cnt_r <= {BIT_CNT_W{1'b0}};
      tx_sh_r    <= 8'h00;
      rx_sh_r    <= 8'h00;
    end else begin
      done <= 1'b0;
      if (accept_s) begin
        busy       <= 1'b1;
        mosi       <= txd[7];
        tx_sh_r    <= txd;
        div_cnt_r  <= {DIV_W{1'b0}};
        half_cnt_r <= {BIT_CNT_W{1'b0}};
        sclk       <= 1'b0;
      end else if (busy) begin
        if (tick_s) begin
          div_cnt_r  <= {DIV_W{1'b0}};
          half_cnt_r <= half_cnt_r + 1'b1;
          if (!half_cnt_r[0]) begin
            sclk    <= 1'b1;
            rx_sh_r <= {rx_sh_r[6:0], miso};
          end else begin
            sclk <= 1'b0;
            if (half_cnt_r == HALF_LAST) begin
              busy <= 1'b0;
              done <= 1'b1;
              rxd  <= rx_sh_r;
              mosi <= 1'b1;
            end else begin
              tx_sh_r <= {tx_sh_r[6:0], 1'b0};
              mosi    <= tx_sh_r[6];
            end
          end
        end else begin
          div_cnt_r <= div_cnt_r + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI shifter for the boot loader (r0) and CPU port (r1).
// Define SPI_ARB_LED_STRETCH_EN to stretch the activity LED; LED_HOLD = 0 removes the LED driver.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DIV      = 0,
  parameter int CS_GAP   = 4,
  parameter int LED_HOLD = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_req,
  input  logic       r0_dev,
  input  logic       r0_start,
  input  logic [7:0] r0_txd,
  output logic       r0_gnt,
  input  logic       r1_req,
  input  logic       r1_dev,
  input  logic       r1_start,
  input  logic [7:0] r1_txd,
  output logic       r1_gnt,
  output logic [7:0] rxd,
  output logic       done,
  output logic       busy,
  output logic       flash_cs_n,
  output logic       sd_cs_n,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       flash_miso,
  input  logic       sd_miso,
  output logic       activity
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  arb_state_e       state_r;
  logic             last_r;
  logic             dev_r;
  logic [GAP_W-1:0] gap_cnt_r;

  logic             start_sel_s;
  logic [7:0]       txd_sel_s;
  logic             req_sel_s;
  logic             miso_sel_s;
  logic             release_s;

  // Route the grantee's strobe/data and the latched device's MISO into the shifter
  always_comb begin
    start_sel_s = 1'b0;
    txd_sel_s   = 8'h00;
    req_sel_s   = 1'b0;
    case (state_r)
      ST_GNT0: begin
        start_sel_s = r0_start;
        txd_sel_s   = r0_txd;
        req_sel_s   = r0_req;
      end
      ST_GNT1: begin
        start_sel_s = r1_start;
        txd_sel_s   = r1_txd;
        req_sel_s   = r1_req;
      end
      default: begin
        start_sel_s = 1'b0;
        txd_sel_s   = 8'h00;
        req_sel_s   = 1'b0;
      end
    endcase
    if (dev_r == DEV_SD) miso_sel_s = sd_miso;
    else                 miso_sel_s = flash_miso;
  end

  // A pending start keeps the bus so a byte never begins after the grant is gone
  assign release_s = ~req_sel_s & ~busy & ~start_sel_s;

  // Arbiter FSM with registered grants and chip selects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      last_r     <= 1'b1;
      dev_r      <= DEV_FLASH;
      gap_cnt_r  <= {GAP_W{1'b0}};
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      flash_cs_n <= 1'b1;
      sd_cs_n    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (r0_req && (!r1_req || last_r)) begin
            state_r                <= ST_GNT0;
            r0_gnt                 <= 1'b1;
            last_r                 <= 1'b0;
            dev_r                  <= r0_dev;
            {sd_cs_n, flash_cs_n}  <= cs_for_dev(r0_dev);
          end else if (r1_req) begin
            state_r                <= ST_GNT1;
            r1_gnt                 <= 1'b1;
            last_r                 <= 1'b1;
            dev_r                  <= r1_dev;
            {sd_cs_n, flash_cs_n}  <= cs_for_dev(r1_dev);
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (release_s) begin
            state_r    <= ST_GAP;
            r0_gnt     <= 1'b0;
            r1_gnt     <= 1'b0;
            flash_cs_n <= 1'b1;
            sd_cs_n    <= 1'b1;
            gap_cnt_r  <= {GAP_W{1'b0}};
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_W'(CS_GAP - 1)) state_r <= ST_IDLE;
          else                                 gap_cnt_r <= gap_cnt_r + 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          r0_gnt     <= 1'b0;
          r1_gnt     <= 1'b0;
          flash_cs_n <= 1'b1;
          sd_cs_n    <= 1'b1;
        end
      endcase
    end
  end

  spi_byte_shifter #(.DIV(DIV)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (start_sel_s),
    .txd   (txd_sel_s),
    .miso  (miso_sel_s),
    .busy  (busy),
    .done  (done),
    .rxd   (rxd),
    .sclk  (spi_clk),
    .mosi  (spi_mosi)
  );

`ifdef SPI_ARB_LED_STRETCH_EN
  logic [LED_HOLD-1:0] led_cnt_r;

  // Any selected cycle reloads the hold counter so short bursts remain visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        led_cnt_r <= {LED_HOLD{1'b0}};
    else if (!flash_cs_n || !sd_cs_n) led_cnt_r <= {LED_HOLD{1'b1}};
    else if (|led_cnt_r)            led_cnt_r <= led_cnt_r - 1'b1;
  end

  assign activity = |led_cnt_r;
`else
  if (LED_HOLD > 0) begin : g_led
    // LED follows "any chip select low" one clock late
    always_ff @(posedge clk or posedge rst) begin
      if (rst) activity <= 1'b0;
      else     activity <= ~flash_cs_n | ~sd_cs_n;
    end
  end else begin : g_no_led
    assign activity = 1'b0;
  end
`endif

endmodule
